// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Single-clock game-flow controller for the VGA arcade tops: start/pause/
// restart state machine, saturating BCD score counter, level selection from
// switches or score, and scroll clock-enable pulses for the sprite address
// generators (replacing divided clocks).
// Optional feature macro: HIGH_SCORE_EN adds the best_bcd high-score output.
module game_flow_ctrl #(
  parameter int DIGITS     = 3,
  parameter int NUM_LEVELS = 4,
  parameter int BASE_DIV   = 1048576,
  parameter int LEVEL_STEP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  restart,
  input  logic                  collision,
  input  logic                  pipe_pass,
  input  logic [NUM_LEVELS-1:0] level_sw,
  output logic [1:0]            state,
  output logic                  scroll_tick,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [NUM_LEVELS-1:0] level_therm,
`ifdef HIGH_SCORE_EN
  output logic [4*DIGITS-1:0]   best_bcd,
`endif
  output logic                  gameover
);

  // Level index width and divider counter width.
  localparam int IW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int CW = $clog2(BASE_DIV + 1);
  localparam logic [CW-1:0] BASE = CW'(BASE_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_gameover;
  logic                    r_tick;
  logic [CW-1:0]           r_cnt;
  logic [NUM_LEVELS-1:0]   r_therm;

  logic [4*DIGITS-1:0]     w_score;
  logic [DIGITS-1:0]       w_nine;
  logic [DIGITS-1:0]       w_carry;
  logic                    w_saturated;
  logic                    w_score_inc;
  logic                    w_run_stay;

  logic [3:0]              w_tens;
  logic [IW-1:0]           w_sw_idx;
  logic [IW-1:0]           w_auto_idx;
  logic [IW-1:0]           w_idx;
  logic [NUM_LEVELS-1:0]   w_therm;
  logic [CW-1:0]           w_period;
  logic [CW-1:0]           w_last;

  // A pipe pass only counts while running, and a collision in the same
  // cycle wins (the bird died clearing the pipe). Restart also suppresses it.
  assign w_score_inc = (r_state == S_RUN) && pipe_pass && !collision && !restart;

  // The divider only advances on edges where the game stays in RUN; any edge
  // that leaves RUN (pause, collision, restart) drops it back to zero.
  assign w_run_stay = (r_state == S_RUN) && !restart && !collision && !pause;

  // Game state machine with registered gameover flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gameover <= 1'b0;
    end else if (restart) begin
      r_state    <= S_IDLE;
      r_gameover <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (collision) begin
            r_state    <= S_OVER;
            r_gameover <= 1'b1;
          end else if (pause) begin
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause || start) r_state <= S_RUN;
        end
        S_OVER: begin
          r_gameover <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_gameover <= 1'b0;
        end
      endcase
    end
  end

  // Saturation: once every digit shows 9 the counter stops instead of
  // wrapping back to zero.
  assign w_saturated = &w_nine;
  assign w_carry[0]  = w_score_inc && !w_saturated;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] r_digit;

      assign w_score[4*gi +: 4] = r_digit;
      assign w_nine[gi]         = (r_digit == 4'd9);

      if (gi < DIGITS - 1) begin : g_carry
        assign w_carry[gi+1] = w_carry[gi] && w_nine[gi];
      end

      // One BCD digit: wraps 9->0 when its incoming carry is set.
      always_ff @(posedge clk) begin
        if (rst || restart) begin
          r_digit <= 4'd0;
        end else if (w_carry[gi]) begin
          r_digit <= w_nine[gi] ? 4'd0 : r_digit + 4'd1;
        end
      end
    end
  endgenerate

  // Tens digit drives automatic levelling; a one-digit score has no tens.
  generate
    if (DIGITS >= 2) begin : g_tens
      assign w_tens = w_score[7:4];
    end else begin : g_no_tens
      assign w_tens = 4'd0;
    end
  endgenerate

  // Manual override: highest switch that is on selects the level.
  always_comb begin
    w_sw_idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (level_sw[i]) w_sw_idx = IW'(i);
    end
  end

  // Automatic level: ceil(tens / LEVEL_STEP), clamped to the top level.
  always_comb begin
    int lvl;
    lvl = (int'(w_tens) + LEVEL_STEP - 1) / LEVEL_STEP;
    if (lvl > NUM_LEVELS - 1) lvl = NUM_LEVELS - 1;
    w_auto_idx = IW'(lvl);
  end

  assign w_idx = (|level_sw) ? w_sw_idx : w_auto_idx;

  // Thermometer code: bits 0..idx lit.
  generate
    for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_therm
      assign w_therm[gi] = (IW'(gi) <= w_idx);
    end
  endgenerate

  // Level LEDs, registered for a clean one-cycle-latency output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_therm <= NUM_LEVELS'(1);
    end else begin
      r_therm <= w_therm;
    end
  end

  // Each level halves the scroll period.
  assign w_period = BASE >> w_idx;
  assign w_last   = w_period - CW'(1);

  // Scroll divider. The >= compare handles a level increase that shortens
  // the period below the current count: tick at once and restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_run_stay) begin
      if (r_cnt >= w_last) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [4*DIGITS-1:0] r_best;
  logic                w_to_over;

  assign w_to_over = (r_state == S_RUN) && collision && !restart;

  // High score, captured on the RUN->OVER edge; only rst clears it. Digits
  // are packed most-significant first and each holds 0..9, so an unsigned
  // compare of the packed vector equals a digit-by-digit compare from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best <= '0;
    end else if (w_to_over && (w_score > r_best)) begin
      r_best <= w_score;
    end
  end

  assign best_bcd = r_best;
`endif

  assign state       = r_state;
  assign gameover    = r_gameover;
  assign scroll_tick = r_tick;
  assign score_bcd   = w_score;
  assign level_therm = r_therm;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed scenarios plus randomized stimulus,
// checked every cycle against a behavioural model of the game rules.
// Define HIGH_SCORE_EN to also check best_bcd.
module tb_game_flow_ctrl;

  localparam int DIGITS = 3;
  localparam int NL     = 4;
  localparam int BASE   = 16;
  localparam int STEP   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0, pause = 1'b0, restart = 1'b0;
  logic          collision = 1'b0, pipe_pass = 1'b0;
  logic [NL-1:0] level_sw = '0;

  logic [1:0]    state, state2;
  logic          scroll_tick, tick2, gameover, gameover2;
  logic [11:0]   score_bcd;
  logic [7:0]    score2;
  logic [NL-1:0] level_therm, therm2;
`ifdef HIGH_SCORE_EN
  logic [11:0]   best_bcd;
  logic [7:0]    best2;
`endif

  game_flow_ctrl #(.DIGITS(DIGITS), .NUM_LEVELS(NL), .BASE_DIV(BASE), .LEVEL_STEP(STEP)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .restart(restart),
    .collision(collision), .pipe_pass(pipe_pass), .level_sw(level_sw),
    .state(state), .scroll_tick(scroll_tick), .score_bcd(score_bcd),
    .level_therm(level_therm),
`ifdef HIGH_SCORE_EN
    .best_bcd(best_bcd),
`endif
    .gameover(gameover)
  );

  // Two-digit instance for the score saturation boundary (99).
  game_flow_ctrl #(.DIGITS(2), .NUM_LEVELS(NL), .BASE_DIV(BASE), .LEVEL_STEP(STEP)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .restart(restart),
    .collision(collision), .pipe_pass(pipe_pass), .level_sw(level_sw),
    .state(state2), .scroll_tick(tick2), .score_bcd(score2),
    .level_therm(therm2),
`ifdef HIGH_SCORE_EN
    .best_bcd(best2),
`endif
    .gameover(gameover2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: game state as 0..3, scores as plain integers,
  // scroll ticks from the cycle stamp of the last tick / RUN entry.
  int m_state = 0;
  int m_score = 0, m_score2 = 0;
  int m_best = 0, m_best2 = 0;
  int m_cyc = 0, m_ref = 0;
  int m_tick = 0, m_therm = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int lvl_idx(input logic [NL-1:0] sw, input int sc);
    int idx, t;
    idx = 0;
    if (sw != '0) begin
      for (int i = 0; i < NL; i++) if (sw[i]) idx = i;
    end else begin
      t = (sc / 10) % 10;
      idx = (t + STEP - 1) / STEP;
      if (idx > NL - 1) idx = NL - 1;
    end
    return idx;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cyc(input bit st, input bit pa, input bit re, input bit co,
                     input bit pp, input logic [NL-1:0] sw, input bit rs);
    int idx, per, nxt;
    @(negedge clk);
    start = st; pause = pa; restart = re; collision = co;
    pipe_pass = pp; level_sw = sw; rst = rs;
    @(posedge clk);
    m_cyc++;
    if (rs) begin
      m_state = 0; m_score = 0; m_score2 = 0; m_best = 0; m_best2 = 0;
      m_tick = 0; m_therm = 1;
    end else begin
      idx = lvl_idx(sw, m_score);
      per = BASE >> idx;
      m_therm = (1 << (idx + 1)) - 1;
      nxt = m_state;
      if (re) nxt = 0;
      else if (m_state == 0 && st) nxt = 1;
      else if (m_state == 1 && co) nxt = 3;
      else if (m_state == 1 && pa) nxt = 2;
      else if (m_state == 2 && (pa || st)) nxt = 1;
      if (!re && m_state == 1 && co) begin
        if (m_score > m_best) m_best = m_score;
        if (m_score2 > m_best2) m_best2 = m_score2;
      end
      if (re) begin
        m_score = 0; m_score2 = 0;
      end else if (m_state == 1 && pp && !co) begin
        if (m_score < 999) m_score++;
        if (m_score2 < 99) m_score2++;
      end
      m_tick = 0;
      if (m_state == 1 && nxt == 1) begin
        if (m_cyc - m_ref >= per) begin
          m_tick = 1;
          m_ref = m_cyc;
        end
      end else if (nxt == 1) begin
        m_ref = m_cyc;
      end
      m_state = nxt;
    end
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("gameover", 32'(gameover), (m_state == 3) ? 32'd1 : 32'd0);
    chk("scroll_tick", 32'(scroll_tick), 32'(m_tick));
    chk("score_bcd", 32'(score_bcd), to_bcd(m_score));
    chk("level_therm", 32'(level_therm), 32'(m_therm));
    chk("state2", 32'(state2), 32'(m_state));
    chk("score2", 32'(score2), to_bcd(m_score2));
`ifdef HIGH_SCORE_EN
    chk("best_bcd", 32'(best_bcd), to_bcd(m_best));
    chk("best2", 32'(best2), to_bcd(m_best2));
`endif
  endtask

  task automatic idle(input int n, input logic [NL-1:0] sw);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, sw, 0);
  endtask

  task automatic passes(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, '0, 0);
  endtask

  initial begin
    logic [NL-1:0] sw_r;
    int rnd_ticks;

    // 1: reset, start, ticks every 16 cycles at level 0
    cyc(0, 0, 0, 0, 0, '0, 1);
    cyc(0, 0, 0, 0, 0, '0, 1);
    chk("rst_therm", 32'(level_therm), 32'h1);
    cyc(1, 0, 0, 0, 0, '0, 0);
    idle(40, '0);
    $display("phase 1 reset/start done checks=%0d", checks);

    // 2: 25 pipe passes -> score 025, level 1
    passes(25);
    idle(1, '0);
    chk("tp2_score", 32'(score_bcd), 32'h025);
    chk("tp2_therm", 32'(level_therm), 32'h3);
    idle(20, '0);
    $display("phase 2 scoring done checks=%0d", checks);

    // 3: collision with pipe_pass, pause ignored in OVER, restart
    cyc(0, 0, 0, 1, 1, '0, 0);
    chk("tp3_score", 32'(score_bcd), 32'h025);
    chk("tp3_over", 32'(gameover), 32'h1);
    idle(20, '0);
    cyc(0, 1, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, 0, '0, 0);
    chk("tp3_stay_over", 32'(state), 32'h3);
    cyc(0, 0, 1, 0, 0, '0, 0);
    chk("tp3_restart", 32'(score_bcd), 32'h0);
    $display("phase 3 gameover/restart done checks=%0d", checks);

    // 4: pause freezes, resume waits a full period
    cyc(1, 0, 0, 0, 0, '0, 0);
    idle(10, '0);
    cyc(0, 1, 0, 0, 0, '0, 0);
    chk("tp4_pause", 32'(state), 32'h2);
    idle(10, '0);
    cyc(0, 1, 0, 0, 0, '0, 0);
    idle(20, '0);
    $display("phase 4 pause/resume done checks=%0d", checks);

    // 5: switch override, then two-digit saturation
    idle(20, 4'b0101);
    chk("tp5_therm", 32'(level_therm), 32'h7);
    cyc(0, 0, 1, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, 0, '0, 0);
    passes(120);
    chk("tp5_sat2", 32'(score2), 32'h99);
    chk("tp5_score", 32'(score_bcd), 32'h120);
    $display("phase 5 level/saturation done checks=%0d", checks);

    // 6: high score retained across restart, cleared by rst
    cyc(0, 0, 0, 0, 0, '0, 1);
    cyc(1, 0, 0, 0, 0, '0, 0);
    passes(7);
    cyc(0, 0, 0, 1, 0, '0, 0);
    cyc(0, 0, 1, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, 0, '0, 0);
    passes(3);
    cyc(0, 0, 0, 1, 0, '0, 0);
`ifdef HIGH_SCORE_EN
    chk("tp6_best", 32'(best_bcd), 32'h007);
`endif
    cyc(0, 0, 0, 0, 0, '0, 1);
`ifdef HIGH_SCORE_EN
    chk("tp6_best_rst", 32'(best_bcd), 32'h0);
`endif
    $display("phase 6 high score done checks=%0d", checks);

    // Randomized play
    sw_r = '0;
    rnd_ticks = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) sw_r = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) == 0, sw_r, $urandom_range(0, 499) == 0);
      if (m_tick != 0) rnd_ticks++;
    end
    $display("phase 7 random done checks=%0d model_ticks=%0d", checks, rnd_ticks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the VGA arcade designs. It replaces the per-top clock-mux level logic and the ad-hoc start/pause/restart handling with a single-clock block. The block contains the game state machine, a saturating BCD score counter of configurable digit count, and level selection from switches or from score. It also generates scroll-enable pulses that sprite address generators use as clock enables instead of divided clocks. It sits between the debounced/one-pulsed keyboard events and the pipe/bird/ground address generators.

Parameters:
DIGITS, 3, number of BCD score digits (1..6)
NUM_LEVELS, 4, number of difficulty levels (2..8)
BASE_DIV, 1048576, scroll period in clk cycles at level 0; must be >= 2**NUM_LEVELS
LEVEL_STEP, 2, tens-digit increment per automatic level step

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, flap/start key
pause  in  1  one-cycle pulse, pause toggle key
restart  in  1  one-cycle pulse, return to idle
collision  in  1  level, bird hit pipe or ground
pipe_pass  in  1  one-cycle pulse, bird cleared a pipe pair
level_sw  in  NUM_LEVELS  manual level override switches
state  out  2  0=IDLE 1=RUN 2=PAUSE 3=OVER
scroll_tick  out  1  one-cycle scroll enable pulse
score_bcd  out  4*DIGITS  score, digit 0 in [3:0]
level_therm  out  NUM_LEVELS  thermometer level indicator for LEDs
gameover  out  1  high while state==OVER

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values: state=IDLE, score_bcd=0, scroll_tick=0, level_therm=1 (level 0), gameover=0, divider=0.
- FSM transitions, priority from highest to lowest:
  - restart from any state -> IDLE; score cleared in the same edge.
  - IDLE: start -> RUN; pause, collision and pipe_pass ignored.
  - RUN: collision -> OVER, and a simultaneous pipe_pass is not counted. Otherwise pause -> PAUSE.
  - PAUSE: pause or start -> RUN; collision ignored.
  - OVER: only restart leaves this state.
- Score:
  - Increments by 1 on pipe_pass only in RUN with no collision that cycle.
  - BCD ripple-carry; each digit wraps 9->0 with carry to the next digit.
  - All digits 9 saturates; no wrap to 0.
  - Update is visible on score_bcd the cycle after the pulse.
- Level index (combinational from registered score and switches):
  - If any level_sw bit is set: idx = position of the highest set bit.
  - Else with t = score digit 1 (tens, 0 when DIGITS==1): idx = min(NUM_LEVELS-1, ceil(t/LEVEL_STEP)).
- level_therm = (2**(idx+1))-1, registered, one-cycle latency.
- Scroll divider:
  - period P = BASE_DIV >> idx.
  - Counts only in RUN; held at 0 in IDLE, PAUSE and OVER.
  - scroll_tick=1 on the cycle the counter reaches P-1, and the counter returns to 0.
  - If idx rises so that count >= P-1, tick on the next cycle and restart.
  - First tick occurs P cycles after entering RUN.
- gameover is registered and equals (state==OVER).
- start/pause pulses longer than one cycle are each treated as a new event per cycle (the caller provides one-pulse inputs).

Optional Feature:
HIGH_SCORE_EN:
- Defined: adds output best_bcd [4*DIGITS], reset to 0 by rst only, not by restart.
- best_bcd updates on the RUN->OVER edge if score_bcd > best_bcd, using BCD compare from the most significant digit down.
- Undefined: no best_bcd port and no related logic.

Test Plan:
1. rst=1 for 2 cycles, then start -> state=1, first scroll_tick exactly BASE_DIV cycles later; with BASE_DIV=16, NUM_LEVELS=4, ticks every 16 cycles.
2. In RUN, 25 pipe_pass pulses -> score_bcd=12'h025, level_therm=4'b0011 (t=2 -> idx 1), tick period 8.
3. In RUN, collision and pipe_pass in the same cycle -> state=3, gameover=1, score unchanged, no further ticks; pause ignored; restart -> state=0, score 0.
4. pause in RUN -> state=2, divider frozen, no ticks; pause again -> RUN, ticks resume after full period P.
5. level_sw=4'b0101 with score 0 -> idx 2, level_therm=4'b0111, period 4; DIGITS=2 at score 99 plus pipe_pass -> stays 8'h99.
6. HIGH_SCORE_EN: score 7 then collision -> best_bcd=7; restart, score 3, collision -> best_bcd stays 7; rst -> best_bcd=0.
